ppu_mem_arbiter: RTL and testbench

- Owns the shared VRAM ($8000-$9FFF) / OAM ($FE00-$FE9F) memory port. Arbitrates it among three requesters: the PPU fetch/OAM-scan path, the CPU bus, and an internal OAM DMA engine started by a write to $FF46.
- Enforces Game Boy mode-based access locking using the PPU mode and LCDC.7.
- Sits between the PPU, the CPU bus decoder and the VRAM/OAM BRAM.

---
 rtl/ppu_mem_arbiter_if.sv | 61 ++++++
 rtl/ppu_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ppu_mem_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_mem_arbiter_if.sv
// ppu_mem_arbiter_if: PPU, CPU, OAM DMA and VRAM/OAM port bundle.
// The arbiter takes the slave side; its environment takes master.
interface ppu_mem_arbiter_if;
  logic        mclk_in;
  logic        lcd_en_in;
  logic [1:0]  mode_in;
  logic        ppu_req_in;
  logic [15:0] ppu_addr_in;
  logic [7:0]  ppu_data_out;
  logic        ppu_valid_out;
  logic        cpu_req_in;
  logic        cpu_we_in;
  logic [15:0] cpu_addr_in;
  logic [7:0]  cpu_wdata_in;
  logic [7:0]  cpu_rdata_out;
  logic        cpu_valid_out;
  logic        dma_start_in;
  logic [7:0]  dma_page_in;
  logic        dma_active_out;
  logic        src_req_out;
  logic [15:0] src_addr_out;
  logic [7:0]  src_data_in;
  logic        src_valid_in;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [15:0] mem_addr_out;
  logic [7:0]  mem_wdata_out;
  logic [7:0]  mem_rdata_in;

  modport slave (
    input  mclk_in, lcd_en_in, mode_in,
    input  ppu_req_in, ppu_addr_in,
    output ppu_data_out, ppu_valid_out,
    input  cpu_req_in, cpu_we_in,
    input  cpu_addr_in, cpu_wdata_in,
    output cpu_rdata_out, cpu_valid_out,
    input  dma_start_in, dma_page_in,
    output dma_active_out,
    output src_req_out, src_addr_out,
    input  src_data_in, src_valid_in,
    output mem_req_out, mem_we_out,
    output mem_addr_out, mem_wdata_out,
    input  mem_rdata_in
  );

  modport master (
    output mclk_in, lcd_en_in, mode_in,
    output ppu_req_in, ppu_addr_in,
    input  ppu_data_out, ppu_valid_out,
    output cpu_req_in, cpu_we_in,
    output cpu_addr_in, cpu_wdata_in,
    input  cpu_rdata_out, cpu_valid_out,
    output dma_start_in, dma_page_in,
    input  dma_active_out,
    input  src_req_out, src_addr_out,
    output src_data_in, src_valid_in,
    input  mem_req_out, mem_we_out,
    input  mem_addr_out, mem_wdata_out,
    output mem_rdata_in
  );
endinterface

// File: rtl/ppu_mem_arbiter.sv
// ppu_mem_arbiter: VRAM/OAM port arbiter with mode locks
// and the $FF46 OAM DMA engine.
module ppu_mem_arbiter #(
  parameter int OAM_BYTES       = 160,
  parameter int DMA_START_DELAY = 1
) (
  input logic              clk_in,
  input logic              rst_in,
  ppu_mem_arbiter_if.slave bus
);
  localparam int IW = $clog2(OAM_BYTES);
  localparam int WW =
    (DMA_START_DELAY > 1) ? $clog2(DMA_START_DELAY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER
  } dma_st_e;

  function automatic logic is_vram(logic [15:0] a);
    return a[15:13] == 3'b100;
  endfunction

  function automatic logic is_oam(logic [15:0] a);
    return (a[15:8] == 8'hFE) && (int'(a[7:0]) < OAM_BYTES);
  endfunction

  dma_st_e       st_q;
  logic [7:0]    page_q;
  logic [IW-1:0] idx_q;
  logic [WW-1:0] wcnt_q;
  logic          src_req_q;
  logic          src_pend_q;
  logic [15:0]   src_addr_q;
  logic [7:0]    byte_q;
  logic          wr_pend_q;
  logic          active_q;

  logic ppu_valid_q, ppu_valid_d;
  logic ppu_mem_q, ppu_mem_d;
  logic cpu_valid_q, cpu_valid_d;
  logic cpu_mem_q, cpu_mem_d;
  logic cpu_ff_q, cpu_ff_d;

  logic lock_vram, lock_oam, dma_wr;
  logic ppu_can, ppu_go, ppu_gnt;
  logic cpu_can, cpu_go, cpu_gnt;

  // A restart in the same cycle kills the pending OAM byte.
  assign dma_wr = rst_in & wr_pend_q & ~bus.dma_start_in;

  assign lock_vram = bus.lcd_en_in & (bus.mode_in == 2'd3);
  assign lock_oam  = bus.lcd_en_in & bus.mode_in[1];

  // The valid cycle blocks re-acceptance of a still-held request.
  assign ppu_can = rst_in & bus.ppu_req_in & ~ppu_valid_q;
  assign ppu_go  = is_vram(bus.ppu_addr_in)
                 | (is_oam(bus.ppu_addr_in) & ~active_q);
  assign ppu_gnt = ppu_can & ppu_go & ~dma_wr;

  assign cpu_can = rst_in & bus.cpu_req_in & ~cpu_valid_q;
  assign cpu_go  = (is_vram(bus.cpu_addr_in) & ~lock_vram)
                 | (is_oam(bus.cpu_addr_in)
                    & ~lock_oam & ~active_q);
  assign cpu_gnt = cpu_can & cpu_go & ~dma_wr & ~ppu_gnt;

  assign ppu_valid_d = ppu_can & (ppu_gnt | ~ppu_go);
  assign ppu_mem_d   = ppu_gnt;
  assign cpu_valid_d = cpu_can & (cpu_gnt | ~cpu_go);
  assign cpu_mem_d   = cpu_gnt & ~bus.cpu_we_in;
  assign cpu_ff_d    = cpu_can & ~cpu_go;

  // Single memory port mux: DMA write, then PPU, then CPU.
  always_comb begin
    bus.mem_req_out   = 1'b0;
    bus.mem_we_out    = 1'b0;
    bus.mem_addr_out  = 16'h0000;
    bus.mem_wdata_out = 8'h00;
    if (dma_wr) begin
      bus.mem_req_out   = 1'b1;
      bus.mem_we_out    = 1'b1;
      bus.mem_addr_out  = {8'hFE, 8'(idx_q)};
      bus.mem_wdata_out = byte_q;
    end else if (ppu_gnt) begin
      bus.mem_req_out  = 1'b1;
      bus.mem_addr_out = bus.ppu_addr_in;
    end else if (cpu_gnt) begin
      bus.mem_req_out   = 1'b1;
      bus.mem_we_out    = bus.cpu_we_in;
      bus.mem_addr_out  = bus.cpu_addr_in;
      bus.mem_wdata_out = bus.cpu_wdata_in;
    end
  end

  assign bus.ppu_valid_out = ppu_valid_q;
  assign bus.ppu_data_out  =
    !ppu_valid_q ? 8'h00 :
    ppu_mem_q    ? bus.mem_rdata_in : 8'hFF;

  assign bus.cpu_valid_out = cpu_valid_q;
  assign bus.cpu_rdata_out =
    !cpu_valid_q ? 8'h00 :
    cpu_mem_q    ? bus.mem_rdata_in :
    cpu_ff_q     ? 8'hFF : 8'h00;

  assign bus.dma_active_out = active_q;
  assign bus.src_req_out    = src_req_q;
  assign bus.src_addr_out   = src_addr_q;

  // Completion flags for PPU and CPU transactions.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ppu_valid_q <= 1'b0;
      ppu_mem_q   <= 1'b0;
      cpu_valid_q <= 1'b0;
      cpu_mem_q   <= 1'b0;
      cpu_ff_q    <= 1'b0;
    end else begin
      ppu_valid_q <= ppu_valid_d;
      ppu_mem_q   <= ppu_mem_d;
      cpu_valid_q <= cpu_valid_d;
      cpu_mem_q   <= cpu_mem_d;
      cpu_ff_q    <= cpu_ff_d;
    end
  end

  // OAM DMA engine: IDLE -> WAIT -> XFER, restartable any time.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      st_q       <= IDLE;
      page_q     <= 8'h00;
      idx_q      <= '0;
      wcnt_q     <= '0;
      src_req_q  <= 1'b0;
      src_pend_q <= 1'b0;
      src_addr_q <= 16'h0000;
      byte_q     <= 8'h00;
      wr_pend_q  <= 1'b0;
      active_q   <= 1'b0;
    end else if (bus.dma_start_in) begin
      st_q       <= WAIT;
      page_q     <= bus.dma_page_in;
      idx_q      <= '0;
      wcnt_q     <= '0;
      src_req_q  <= 1'b0;
      src_pend_q <= 1'b0;
      wr_pend_q  <= 1'b0;
      active_q   <= 1'b1;
    end else begin
      src_req_q <= 1'b0;
      unique case (st_q)
        IDLE: ;
        WAIT: begin
          if (bus.mclk_in) begin
            if (wcnt_q == WW'(DMA_START_DELAY - 1)) begin
              st_q   <= XFER;
              wcnt_q <= '0;
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
            end
          end
        end
        XFER: begin
          if (bus.mclk_in && !src_pend_q && !wr_pend_q) begin
            src_req_q  <= 1'b1;
            src_pend_q <= 1'b1;
            src_addr_q <= {page_q, 8'(idx_q)};
          end
          if (src_pend_q && bus.src_valid_in) begin
            src_pend_q <= 1'b0;
            byte_q     <= bus.src_data_in;
            wr_pend_q  <= 1'b1;
          end
          if (wr_pend_q) begin
            wr_pend_q <= 1'b0;
            idx_q     <= idx_q + 1'b1;
            if (idx_q == IW'(OAM_BYTES - 1)) begin
              st_q     <= IDLE;
              active_q <= 1'b0;
            end
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// tb_ppu_mem_arbiter: directed bench for ppu_mem_arbiter.
// Memory and DMA source are small behavioural models.
module tb_ppu_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ppu_mem_arbiter_if bus();

  ppu_mem_arbiter #(
    .OAM_BYTES(160),
    .DMA_START_DELAY(1)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_memreq = 0;
  int n_memwr = 0;
  int n_mact = 0;
  int cyc_n = 0;
  int mph = 0;
  logic [7:0]  mem [0:65535];
  logic [15:0] wl_addr[$];
  logic [7:0]  wl_data[$];
  int          wl_cyc[$];

  // VRAM/OAM model: read data one cycle after the request.
  always @(posedge clk) begin
    if (bus.mem_req_out) begin
      if (bus.mem_we_out)
        mem[bus.mem_addr_out] <= bus.mem_wdata_out;
      else
        bus.mem_rdata_in <= mem[bus.mem_addr_out];
    end
  end

  // DMA source: byte = addr_hi ^ addr_lo, one cycle later.
  always @(posedge clk) begin
    bus.src_valid_in <= bus.src_req_out;
    bus.src_data_in  <= bus.src_addr_out[15:8]
                      ^ bus.src_addr_out[7:0];
  end

  // Monitor: port usage, OAM write log, active M-cycles.
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (bus.mem_req_out)
      n_memreq <= n_memreq + 1;
    if (bus.mem_req_out && bus.mem_we_out)
      n_memwr <= n_memwr + 1;
    if (bus.mem_req_out && bus.mem_we_out
        && bus.mem_addr_out[15:8] == 8'hFE) begin
      wl_addr.push_back(bus.mem_addr_out);
      wl_data.push_back(bus.mem_wdata_out);
      wl_cyc.push_back(cyc_n);
    end
    if (bus.dma_active_out && bus.mclk_in)
      n_mact <= n_mact + 1;
  end

  // M-cycle strobe every fourth clock.
  initial begin
    bus.mclk_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mph = (mph + 1) % 4;
      bus.mclk_in = (mph == 0);
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_op(input logic we,
                        input logic [15:0] a,
                        input logic [7:0] wd,
                        output logic [7:0] rd,
                        output int lat,
                        output int nreq);
    int r0;
    r0 = n_memreq;
    lat = -1;
    rd = 8'h00;
    bus.cpu_we_in = we;
    bus.cpu_addr_in = a;
    bus.cpu_wdata_in = wd;
    bus.cpu_req_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cpu_valid_out) begin
        lat = i;
        rd = bus.cpu_rdata_out;
        break;
      end
      cyc();
    end
    cyc();
    bus.cpu_req_in = 1'b0;
    nreq = n_memreq - r0;
  endtask

  task automatic ppu_op(input logic [15:0] a,
                        output logic [7:0] rd,
                        output int lat);
    lat = -1;
    rd = 8'h00;
    bus.ppu_addr_in = a;
    bus.ppu_req_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.ppu_valid_out) begin
        lat = i;
        rd = bus.ppu_data_out;
        break;
      end
      cyc();
    end
    cyc();
    bus.ppu_req_in = 1'b0;
  endtask

  task automatic wait_wl(input int n, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (wl_addr.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic ok;
    int lat, nreq, w0, base, m0, n, errs, s0;

    rst_n = 1'b0;
    bus.lcd_en_in = 1'b1;
    bus.mode_in = 2'd0;
    bus.ppu_req_in = 1'b1;
    bus.ppu_addr_in = 16'h9800;
    bus.cpu_req_in = 1'b1;
    bus.cpu_we_in = 1'b0;
    bus.cpu_addr_in = 16'h8000;
    bus.cpu_wdata_in = 8'h00;
    bus.dma_start_in = 1'b1;
    bus.dma_page_in = 8'hC1;

    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      chk("rst_memreq", bus.mem_req_out, 0);
      chk("rst_cpuv", bus.cpu_valid_out, 0);
      chk("rst_ppuv", bus.ppu_valid_out, 0);
      chk("rst_dma", bus.dma_active_out, 0);
    end
    cyc();
    rst_n = 1'b1;
    bus.ppu_req_in = 1'b0;
    bus.cpu_req_in = 1'b0;
    bus.dma_start_in = 1'b0;
    @(negedge clk);
    chk("rst_outs",
        {bus.ppu_data_out, bus.ppu_valid_out,
         bus.cpu_rdata_out, bus.cpu_valid_out,
         bus.dma_active_out, bus.src_req_out,
         bus.src_addr_out, bus.mem_req_out,
         bus.mem_we_out, bus.mem_addr_out,
         bus.mem_wdata_out}, 0);
    cyc();

    w0 = n_memwr;
    cpu_op(1'b1, 16'h8000, 8'h5A, rd, lat, nreq);
    chk("wr_lat", lat, 1);
    chk("wr_nreq", nreq, 1);
    chk("wr_count", n_memwr - w0, 1);
    cpu_op(1'b0, 16'h8000, 8'h00, rd, lat, nreq);
    chk("rd_lat", lat, 1);
    chk("rd_nreq", nreq, 1);
    chk("rd_data", rd, 8'h5A);
    cpu_op(1'b1, 16'hFE10, 8'h33, rd, lat, nreq);
    cpu_op(1'b1, 16'h9800, 8'h3C, rd, lat, nreq);

    bus.mode_in = 2'd3;
    cpu_op(1'b0, 16'h8123, 8'h00, rd, lat, nreq);
    chk("m3_lat", lat, 1);
    chk("m3_nreq", nreq, 0);
    chk("m3_data", rd, 8'hFF);
    ppu_op(16'h9800, rd, lat);
    chk("m3_ppu", rd, 8'h3C);
    bus.mode_in = 2'd2;
    cpu_op(1'b1, 16'hFE10, 8'h77, rd, lat, nreq);
    chk("m2_wr_lat", lat, 1);
    chk("m2_wr_nreq", nreq, 0);
    cpu_op(1'b0, 16'h8000, 8'h00, rd, lat, nreq);
    chk("m2_vram", rd, 8'h5A);
    bus.mode_in = 2'd0;
    cpu_op(1'b0, 16'hFE10, 8'h00, rd, lat, nreq);
    chk("m0_oam_old", rd, 8'h33);
    bus.lcd_en_in = 1'b0;
    bus.mode_in = 2'd3;
    cpu_op(1'b1, 16'h8123, 8'hA5, rd, lat, nreq);
    chk("lcdoff_nreq", nreq, 1);
    cpu_op(1'b0, 16'h8123, 8'h00, rd, lat, nreq);
    chk("lcdoff_data", rd, 8'hA5);
    bus.lcd_en_in = 1'b1;
    bus.mode_in = 2'd0;
    cpu_op(1'b0, 16'hFEA0, 8'h00, rd, lat, nreq);
    chk("unm_lat", lat, 1);
    chk("unm_nreq", nreq, 0);
    chk("unm_data", rd, 8'hFF);
    cpu_op(1'b0, 16'hC000, 8'h00, rd, lat, nreq);
    chk("unm_c000", rd, 8'hFF);

    bus.ppu_addr_in = 16'h9800;
    bus.ppu_req_in = 1'b1;
    bus.cpu_addr_in = 16'h8000;
    bus.cpu_we_in = 1'b0;
    bus.cpu_req_in = 1'b1;
    @(negedge clk);
    chk("c0_req", bus.mem_req_out, 1);
    chk("c0_addr", bus.mem_addr_out, 16'h9800);
    chk("c0_we", bus.mem_we_out, 0);
    cyc();
    bus.ppu_req_in = 1'b0;
    @(negedge clk);
    chk("c1_ppuv", bus.ppu_valid_out, 1);
    chk("c1_ppud", bus.ppu_data_out, 8'h3C);
    chk("c1_cpuv", bus.cpu_valid_out, 0);
    chk("c1_req", bus.mem_req_out, 1);
    chk("c1_addr", bus.mem_addr_out, 16'h8000);
    cyc();
    @(negedge clk);
    chk("c2_cpuv", bus.cpu_valid_out, 1);
    chk("c2_cpud", bus.cpu_rdata_out, 8'h5A);
    chk("c2_ppuv", bus.ppu_valid_out, 0);
    cyc();
    bus.cpu_req_in = 1'b0;

    base = wl_addr.size();
    m0 = n_mact;
    bus.dma_page_in = 8'hC1;
    bus.dma_start_in = 1'b1;
    cyc();
    bus.dma_start_in = 1'b0;
    @(negedge clk);
    chk("dma_act", bus.dma_active_out, 1);
    cyc();
    cpu_op(1'b0, 16'hFE05, 8'h00, rd, lat, nreq);
    chk("dma_cpu_oam", rd, 8'hFF);
    chk("dma_cpu_lat", lat, 1);
    ppu_op(16'hFE10, rd, lat);
    chk("dma_ppu_oam", rd, 8'hFF);
    chk("dma_ppu_lat", lat, 1);
    cpu_op(1'b0, 16'h8000, 8'h00, rd, lat, nreq);
    chk("dma_cpu_vram", rd, 8'h5A);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!bus.dma_active_out) break;
    end
    chk("dma_done", bus.dma_active_out, 0);
    cyc();
    n = wl_addr.size() - base;
    chk("dma_wcount", n, 160);
    chk("dma_mcyc", n_mact - m0, 161);
    errs = 0;
    for (int k = 0; k < n && k < 160; k++) begin
      if (wl_addr[base + k] != 16'hFE00 + 16'(k)) errs++;
      if (wl_data[base + k] != (8'hC1 ^ 8'(k))) errs++;
      if (k > 0 && wl_cyc[base + k] - wl_cyc[base + k - 1] != 4)
        errs++;
    end
    chk("dma_errs", errs, 0);
    if (n >= 160) begin
      chk("dma_first_a", wl_addr[base], 16'hFE00);
      chk("dma_first_d", wl_data[base], 8'hC1);
      chk("dma_last_a", wl_addr[base + 159], 16'hFE9F);
      chk("dma_last_d", wl_data[base + 159], 8'h5E);
    end
    cpu_op(1'b0, 16'hFE05, 8'h00, rd, lat, nreq);
    chk("post_dma_oam", rd, 8'hC4);

    base = wl_addr.size();
    bus.dma_page_in = 8'hC1;
    bus.dma_start_in = 1'b1;
    cyc();
    bus.dma_start_in = 1'b0;
    wait_wl(base + 50, ok);
    chk("rs_reach50", ok, 1);
    cyc();
    bus.dma_page_in = 8'hD0;
    bus.dma_start_in = 1'b1;
    cyc();
    bus.dma_start_in = 1'b0;
    wait_wl(base + 52, ok);
    chk("rs_reach52", ok, 1);
    if (ok) begin
      chk("rs_addr0", wl_addr[base + 50], 16'hFE00);
      chk("rs_data0", wl_data[base + 50], 8'hD0);
      chk("rs_addr1", wl_addr[base + 51], 16'hFE01);
      chk("rs_data1", wl_data[base + 51], 8'hD1);
    end
    wait_wl(base + 130, ok);
    chk("rs_reach80", ok, 1);
    s0 = wl_addr.size();
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rs_abort", bus.dma_active_out, 0);
    repeat (40) cyc();
    chk("rs_nowr", wl_addr.size() - s0, 0);
    cpu_op(1'b0, 16'h8000, 8'h00, rd, lat, nreq);
    chk("post_rst_rd", rd, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
